// File: rtl/alu_writeback_if.sv
// Writeback-stage bus: ALU result and destination in, committed register file
// and pending-write status out. The master side drives results, the slave is the stage.
interface alu_writeback_if;
  logic [3:0] dst_sel;
  logic [7:0] alu_out;
  logic [3:0] alu_flags;
  logic [3:0] flag_we;
  logic       stall;

  logic [7:0] a;
  logic [7:0] x;
  logic [7:0] y;
  logic [7:0] sp;
  logic [7:0] bal;
  logic [7:0] bah;
  logic [7:0] adl;
  logic [7:0] pcl;
  logic [7:0] pch;
  logic [7:0] temp_status;
  logic       pend_valid;
  logic [3:0] pend_dst;

  modport master (
    output dst_sel, alu_out, alu_flags, flag_we, stall,
    input  a, x, y, sp, bal, bah, adl, pcl, pch, temp_status, pend_valid, pend_dst
  );

  modport slave (
    input  dst_sel, alu_out, alu_flags, flag_we, stall,
    output a, x, y, sp, bal, bah, adl, pcl, pch, temp_status, pend_valid, pend_dst
  );
endinterface

// File: rtl/alu_writeback.sv
// 6502 result writeback: a one-entry capture register followed by a commit into
// the architectural/temporary register named by the captured destination.
module alu_writeback #(
  parameter logic [7:0] SP_RST = 8'hFD,
  parameter logic [7:0] P_RST  = 8'h24
) (
  input logic            clk,
  input logic            rst,
  alu_writeback_if.slave wb
);

  localparam logic [3:0] DST_NONE   = 4'd0;
  localparam logic [3:0] DST_A      = 4'd1;
  localparam logic [3:0] DST_X      = 4'd2;
  localparam logic [3:0] DST_Y      = 4'd3;
  localparam logic [3:0] DST_SP     = 4'd4;
  localparam logic [3:0] DST_BAL    = 4'd5;
  localparam logic [3:0] DST_BAH    = 4'd6;
  localparam logic [3:0] DST_ADL    = 4'd7;
  localparam logic [3:0] DST_PCL    = 4'd8;
  localparam logic [3:0] DST_PCH    = 4'd9;
  localparam logic [3:0] DST_STATUS = 4'd10;

  function automatic logic dst_known(input logic [3:0] d);
    return (d >= DST_A) && (d <= DST_STATUS);
  endfunction

  // Flags arrive as {N,V,Z,C}; they land in P bits 7, 6, 1 and 0.
  function automatic logic [7:0] merge_flags(input logic [7:0] p,
                                             input logic [3:0] f,
                                             input logic [3:0] we);
    logic [7:0] r;
    r = p;
    if (we[3]) r[7] = f[3];
    if (we[2]) r[6] = f[2];
    if (we[1]) r[1] = f[1];
    if (we[0]) r[0] = f[0];
    return r;
  endfunction

  // A direct P load keeps the unused bit 5 high and the B bit low.
  function automatic logic [7:0] status_load(input logic [7:0] v);
    return {v[7:6], 1'b1, 1'b0, v[3:0]};
  endfunction

  // Capture stage
  logic       c_vld_q,   c_vld_d;
  logic [3:0] c_dst_q,   c_dst_d;
  logic [7:0] c_data_q,  c_data_d;
  logic [3:0] c_flags_q, c_flags_d;
  logic [3:0] c_fwe_q,   c_fwe_d;

  // Commit stage (register file)
  logic [7:0] a_q,   a_d;
  logic [7:0] x_q,   x_d;
  logic [7:0] y_q,   y_d;
  logic [7:0] sp_q,  sp_d;
  logic [7:0] bal_q, bal_d;
  logic [7:0] bah_q, bah_d;
  logic [7:0] adl_q, adl_d;
  logic [7:0] pcl_q, pcl_d;
  logic [7:0] pch_q, pch_d;
  logic [7:0] p_q,   p_d;

  always_comb begin
    c_vld_d   = c_vld_q;
    c_dst_d   = c_dst_q;
    c_data_d  = c_data_q;
    c_flags_d = c_flags_q;
    c_fwe_d   = c_fwe_q;
    a_d   = a_q;
    x_d   = x_q;
    y_d   = y_q;
    sp_d  = sp_q;
    bal_d = bal_q;
    bah_d = bah_q;
    adl_d = adl_q;
    pcl_d = pcl_q;
    pch_d = pch_q;
    p_d   = p_q;

    if (!wb.stall) begin
      // Reserved codes are normalised to NONE so pend_dst never shows them.
      c_vld_d   = dst_known(wb.dst_sel) || (wb.flag_we != 4'b0000);
      c_dst_d   = dst_known(wb.dst_sel) ? wb.dst_sel : DST_NONE;
      c_data_d  = wb.alu_out;
      c_flags_d = wb.alu_flags;
      c_fwe_d   = wb.flag_we;

      if (c_vld_q) begin
        case (c_dst_q)
          DST_A:   a_d   = c_data_q;
          DST_X:   x_d   = c_data_q;
          DST_Y:   y_d   = c_data_q;
          DST_SP:  sp_d  = c_data_q;
          DST_BAL: bal_d = c_data_q;
          DST_BAH: bah_d = c_data_q;
          DST_ADL: adl_d = c_data_q;
          DST_PCL: pcl_d = c_data_q;
          DST_PCH: pch_d = c_data_q;
          default: ;
        endcase

        if (c_dst_q == DST_STATUS) p_d = status_load(c_data_q);
        else                       p_d = merge_flags(p_q, c_flags_q, c_fwe_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_vld_q <= 1'b0;
      c_dst_q <= DST_NONE;
    end else begin
      c_vld_q <= c_vld_d;
      c_dst_q <= c_dst_d;
    end
  end

  // Payload is qualified by c_vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    c_data_q  <= c_data_d;
    c_flags_q <= c_flags_d;
    c_fwe_q   <= c_fwe_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= 8'h00;
      x_q   <= 8'h00;
      y_q   <= 8'h00;
      sp_q  <= SP_RST;
      bal_q <= 8'h00;
      bah_q <= 8'h00;
      adl_q <= 8'h00;
      pcl_q <= 8'h00;
      pch_q <= 8'h00;
      p_q   <= P_RST;
    end else begin
      a_q   <= a_d;
      x_q   <= x_d;
      y_q   <= y_d;
      sp_q  <= sp_d;
      bal_q <= bal_d;
      bah_q <= bah_d;
      adl_q <= adl_d;
      pcl_q <= pcl_d;
      pch_q <= pch_d;
      p_q   <= p_d;
    end
  end

  assign wb.a           = a_q;
  assign wb.x           = x_q;
  assign wb.y           = y_q;
  assign wb.sp          = sp_q;
  assign wb.bal         = bal_q;
  assign wb.bah         = bah_q;
  assign wb.adl         = adl_q;
  assign wb.pcl         = pcl_q;
  assign wb.pch         = pch_q;
  assign wb.temp_status = p_q;
  assign wb.pend_valid  = c_vld_q;
  assign wb.pend_dst    = c_vld_q ? c_dst_q : DST_NONE;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: vector table for the steady pipeline plus
// hand sequences for reset, stall and reset-during-pending-write.
module tb_alu_writeback;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  alu_writeback_if wb ();

  alu_writeback #(.SP_RST(8'hFD), .P_RST(8'h24)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] dst;
    logic [7:0] dat;
    logic [3:0] flg;
    logic [3:0] fwe;
    logic       pv;
    logic [3:0] pd;
    logic [3:0] sel;
    logic [7:0] val;
    logic [7:0] p;
  } vec_t;

  vec_t vec [16];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] get_out(input logic [3:0] sel);
    case (sel)
      4'd1:    return wb.a;
      4'd2:    return wb.x;
      4'd3:    return wb.y;
      4'd4:    return wb.sp;
      4'd5:    return wb.bal;
      4'd6:    return wb.bah;
      4'd7:    return wb.adl;
      4'd8:    return wb.pcl;
      4'd9:    return wb.pch;
      default: return wb.temp_status;
    endcase
  endfunction

  task automatic drive(input logic [3:0] d, input logic [7:0] v,
                       input logic [3:0] f, input logic [3:0] we, input logic st);
    wb.dst_sel   = d;
    wb.alu_out   = v;
    wb.alu_flags = f;
    wb.flag_we   = we;
    wb.stall     = st;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_a"},   wb.a,   8'h00);
    chk({tag, "_x"},   wb.x,   8'h00);
    chk({tag, "_y"},   wb.y,   8'h00);
    chk({tag, "_sp"},  wb.sp,  8'hFD);
    chk({tag, "_bal"}, wb.bal, 8'h00);
    chk({tag, "_bah"}, wb.bah, 8'h00);
    chk({tag, "_adl"}, wb.adl, 8'h00);
    chk({tag, "_pcl"}, wb.pcl, 8'h00);
    chk({tag, "_pch"}, wb.pch, 8'h00);
    chk({tag, "_p"},   wb.temp_status, 8'h24);
    chk({tag, "_pv"},  {7'd0, wb.pend_valid}, 8'h00);
    chk({tag, "_pd"},  {4'd0, wb.pend_dst}, 8'h00);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    drive(4'd0, 8'h00, 4'h0, 4'h0, 1'b0);

    // Each row: inputs captured at the edge, then expected pend_* and the
    // value of one chosen register plus P right after that edge.
    //          dst    dat    flg      fwe      pv  pd     sel    val    p
    vec[0]  = '{4'd1,  8'h12, 4'b0000, 4'b1010, 1, 4'd1,  4'd1, 8'h00, 8'h24};
    vec[1]  = '{4'd2,  8'h78, 4'b0000, 4'b0000, 1, 4'd2,  4'd1, 8'h12, 8'h24};
    vec[2]  = '{4'd3,  8'h00, 4'b0010, 4'b1010, 1, 4'd3,  4'd2, 8'h78, 8'h24};
    vec[3]  = '{4'd6,  8'h80, 4'b1000, 4'b1010, 1, 4'd6,  4'd3, 8'h00, 8'h26};
    vec[4]  = '{4'd7,  8'h34, 4'b0001, 4'b0001, 1, 4'd7,  4'd6, 8'h80, 8'hA4};
    vec[5]  = '{4'd12, 8'h55, 4'b0000, 4'b0000, 0, 4'd0,  4'd7, 8'h34, 8'hA5};
    vec[6]  = '{4'd0,  8'h00, 4'b0100, 4'b0100, 1, 4'd0,  4'd8, 8'h00, 8'hA5};
    vec[7]  = '{4'd10, 8'hFF, 4'b0000, 4'b1111, 1, 4'd10, 4'd8, 8'h00, 8'hE5};
    vec[8]  = '{4'd8,  8'h3C, 4'b0000, 4'b0000, 1, 4'd8,  4'd8, 8'h00, 8'hEF};
    vec[9]  = '{4'd4,  8'hDE, 4'b0000, 4'b0000, 1, 4'd4,  4'd8, 8'h3C, 8'hEF};
    vec[10] = '{4'd4,  8'hDD, 4'b0000, 4'b0000, 1, 4'd4,  4'd4, 8'hDE, 8'hEF};
    vec[11] = '{4'd0,  8'h00, 4'b0000, 4'b0000, 0, 4'd0,  4'd4, 8'hDD, 8'hEF};
    vec[12] = '{4'd5,  8'h56, 4'b0000, 4'b0000, 1, 4'd5,  4'd5, 8'h00, 8'hEF};
    vec[13] = '{4'd0,  8'h00, 4'b0000, 4'b0000, 0, 4'd0,  4'd5, 8'h56, 8'hEF};
    vec[14] = '{4'd10, 8'h00, 4'b1111, 4'b1111, 1, 4'd10, 4'd5, 8'h56, 8'hEF};
    vec[15] = '{4'd0,  8'h00, 4'b0000, 4'b0000, 0, 4'd0,  4'd9, 8'h00, 8'h20};

    // Asynchronous reset: values visible before any clock edge.
    #1;
    chk_reset_state("rst_async");
    step();
    step();
    chk_reset_state("rst_held");
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vec[i].dst, vec[i].dat, vec[i].flg, vec[i].fwe, 1'b0);
      step();
      chk($sformatf("v%0d_pv", i), {7'd0, wb.pend_valid}, {7'd0, vec[i].pv});
      chk($sformatf("v%0d_pd", i), {4'd0, wb.pend_dst}, {4'd0, vec[i].pd});
      chk($sformatf("v%0d_reg%0d", i, vec[i].sel), get_out(vec[i].sel), vec[i].val);
      chk($sformatf("v%0d_p", i), wb.temp_status, vec[i].p);
    end

    // Stall: a PCH write held in capture for two stalled edges.
    drive(4'd9, 8'h9A, 4'h0, 4'h0, 1'b0);
    step();
    chk("stl_pd0", {4'd0, wb.pend_dst}, 8'h09);
    drive(4'd1, 8'h11, 4'b1111, 4'b1111, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("stl%0d_pch", i), wb.pch, 8'h00);
      chk($sformatf("stl%0d_pv", i), {7'd0, wb.pend_valid}, 8'h01);
      chk($sformatf("stl%0d_pd", i), {4'd0, wb.pend_dst}, 8'h09);
      chk($sformatf("stl%0d_p", i), wb.temp_status, 8'h20);
    end
    drive(4'd0, 8'h00, 4'h0, 4'h0, 1'b0);
    step();
    chk("stl_pch", wb.pch, 8'h9A);
    chk("stl_pv_clr", {7'd0, wb.pend_valid}, 8'h00);
    step();
    chk("stl_a_kept", wb.a, 8'h12);
    chk("stl_p_kept", wb.temp_status, 8'h20);

    // Reset while a BAL write is pending: it must never commit.
    drive(4'd5, 8'h77, 4'b1000, 4'b1000, 1'b0);
    step();
    chk("mid_pv", {7'd0, wb.pend_valid}, 8'h01);
    chk("mid_bal_pre", wb.bal, 8'h56);
    #2 rst = 1'b1;
    #1;
    chk_reset_state("mid_rst");
    #1 rst = 1'b0;
    drive(4'd0, 8'h00, 4'h0, 4'h0, 1'b0);
    step();
    chk("mid_bal_post", wb.bal, 8'h00);
    chk("mid_pv_post", {7'd0, wb.pend_valid}, 8'h00);
    chk("mid_p_post", wb.temp_status, 8'h24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
